// File: rtl/vga_timing_gen_if.sv
// Signal bundle of vga_timing_gen: colour/enable from the pixel source,
// counters, pixel request, sync and DAC colour back out.
interface vga_timing_gen_if;
    logic       enable;
    logic [2:0] color_r_in;
    logic [2:0] color_g_in;
    logic [2:0] color_b_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pixel_req;
    logic       frame_start;
    logic [2:0] color_r_readdata;
    logic [2:0] color_g_readdata;
    logic [2:0] color_b_readdata;
    logic       hsync_n;
    logic       vsync_n;
    logic       printting;

    modport master (
        output enable, color_r_in, color_g_in, color_b_in,
        input  pixel_x, pixel_y, pixel_req, frame_start,
               color_r_readdata, color_g_readdata, color_b_readdata,
               hsync_n, vsync_n, printting
    );

    modport slave (
        input  enable, color_r_in, color_g_in, color_b_in,
        output pixel_x, pixel_y, pixel_req, frame_start,
               color_r_readdata, color_g_readdata, color_b_readdata,
               hsync_n, vsync_n, printting
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: 25 MHz pixel tick from a 50 MHz clock,
// h/v counters, and a 2-tick delay line aligning syncs with sampled colour.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input  logic            clk_clk,
    input  logic            reset_reset,
    vga_timing_gen_if.slave bus
);
    localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    // ST_WAIT holds the counters at 0,0 until the first tick loads them as visible.
    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    state_t     state_q;
    logic       tick_q;
    logic [9:0] h_q, v_q;
    logic [9:0] h_d, v_d;
    logic       pixel_req_q, pixel_req_d;
    logic       frame_start_q, frame_start_d;
    logic       hs1_q, vs1_q, vis1_q;
    logic       hs_raw, vs_raw;
    logic       hsync_n_q, vsync_n_q, printting_q;
    logic [2:0] r_q, g_q, b_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (state_q == ST_RUN) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        pixel_req_d   = (h_d < H_VIS_END) && (v_d < V_VIS_END);
        frame_start_d = (h_d == '0) && (v_d == '0);
        hs_raw        = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
        vs_raw        = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= ST_WAIT;
            tick_q        <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            pixel_req_q   <= 1'b0;
            frame_start_q <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            vis1_q        <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            printting_q   <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            tick_q        <= ~tick_q;
            frame_start_q <= 1'b0;
            if (tick_q) begin
                state_q       <= ST_RUN;
                h_q           <= h_d;
                v_q           <= v_d;
                pixel_req_q   <= pixel_req_d;
                frame_start_q <= frame_start_d;
                // Stage 1 captures the raw timing of the counters now on pixel_x/y;
                // stage 2 (the output registers) captures colour from the source.
                hs1_q         <= hs_raw;
                vs1_q         <= vs_raw;
                vis1_q        <= pixel_req_q;
                hsync_n_q     <= ~hs1_q;
                vsync_n_q     <= ~vs1_q;
                printting_q   <= vis1_q;
                if (vis1_q && bus.enable) begin
                    r_q <= bus.color_r_in;
                    g_q <= bus.color_g_in;
                    b_q <= bus.color_b_in;
                end else begin
                    r_q <= '0;
                    g_q <= '0;
                    b_q <= '0;
                end
            end
        end
    end

    assign bus.pixel_x          = h_q;
    assign bus.pixel_y          = v_q;
    assign bus.pixel_req        = pixel_req_q;
    assign bus.frame_start      = frame_start_q;
    assign bus.hsync_n          = hsync_n_q;
    assign bus.vsync_n          = vsync_n_q;
    assign bus.printting        = printting_q;
    assign bus.color_r_readdata = r_q;
    assign bus.color_g_readdata = g_q;
    assign bus.color_b_readdata = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: cold-start vector table, line/frame
// period measurement, enable blanking and mid-frame reset sequences.
module tb_vga_timing_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        white = 1'b0;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    vga_timing_gen_if vif();

    // Full horizontal timing; vertical shortened to 12 lines (6/2/2/2) so two
    // whole frames fit in a short run.
    vga_timing_gen #(
        .V_ACTIVE(6),
        .V_FRONT (2),
        .V_SYNC  (2),
        .V_BACK  (2)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (vif)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int unsigned c;
        int          px, py, preq, fs, hs, vs, prt, cr;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int unsigned c, input int px, input int py, input int preq,
                       input int fs, input int hs, input int vs, input int prt, input int cr);
        vec_t v;
        v.c = c; v.px = px; v.py = py; v.preq = preq; v.fs = fs;
        v.hs = hs; v.vs = vs; v.prt = prt; v.cr = cr;
        tbl.push_back(v);
    endtask

    // Upstream pixel source: returns pixel_x[2:0] on all channels one tick late.
    initial begin
        logic [2:0] d1, d2;
        d1 = '0;
        d2 = '0;
        vif.enable     = 1'b1;
        vif.color_r_in = '0;
        vif.color_g_in = '0;
        vif.color_b_in = '0;
        forever begin
            @(negedge clk);
            vif.color_r_in = white ? 3'b111 : d2;
            vif.color_g_in = white ? 3'b111 : d2;
            vif.color_b_in = white ? 3'b111 : d2;
            d2 = d1;
            d1 = vif.pixel_x[2:0];
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, ".pixel_x"},     int'(vif.pixel_x), 0);
        chk({tag, ".pixel_y"},     int'(vif.pixel_y), 0);
        chk({tag, ".pixel_req"},   int'(vif.pixel_req), 0);
        chk({tag, ".frame_start"}, int'(vif.frame_start), 0);
        chk({tag, ".hsync_n"},     int'(vif.hsync_n), 1);
        chk({tag, ".vsync_n"},     int'(vif.vsync_n), 1);
        chk({tag, ".printting"},   int'(vif.printting), 0);
        chk({tag, ".r"},           int'(vif.color_r_readdata), 0);
        chk({tag, ".g"},           int'(vif.color_g_readdata), 0);
        chk({tag, ".b"},           int'(vif.color_b_readdata), 0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            int unsigned guard = 0;
            string n;
            while (cyc < tbl[i].c && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            n = $sformatf("%s.c%0d", tag, tbl[i].c);
            chk({n, ".cycle"},       int'(cyc), int'(tbl[i].c));
            chk({n, ".pixel_x"},     int'(vif.pixel_x), tbl[i].px);
            chk({n, ".pixel_y"},     int'(vif.pixel_y), tbl[i].py);
            chk({n, ".pixel_req"},   int'(vif.pixel_req), tbl[i].preq);
            chk({n, ".frame_start"}, int'(vif.frame_start), tbl[i].fs);
            chk({n, ".hsync_n"},     int'(vif.hsync_n), tbl[i].hs);
            chk({n, ".vsync_n"},     int'(vif.vsync_n), tbl[i].vs);
            chk({n, ".printting"},   int'(vif.printting), tbl[i].prt);
            chk({n, ".r"},           int'(vif.color_r_readdata), tbl[i].cr);
        end
    endtask

    task automatic wait_xy(input logic [9:0] x, input logic [9:0] y, input string tag);
        int unsigned g = 0;
        while (!(vif.pixel_x == x && vif.pixel_y == y) && g < 30000) begin
            @(negedge clk);
            g++;
        end
        chk(tag, int'(vif.pixel_x == x && vif.pixel_y == y), 1);
    endtask

    task automatic monitor(input int unsigned n);
        logic p_hs, p_vs, p_prt, p_fs;
        logic hs_in, vs_in, prt_in;
        int unsigned hs_last, vs_last, prt_last, fs_last;
        int hs_falls, hs_lows, hs_bad_per, hs_bad_low;
        int vs_falls, vs_lows, vs_bad_per, vs_bad_low;
        int prt_runs, prt_bad, fs_hi, fs_pulses, fs_bad, col_bad;
        p_hs = vif.hsync_n; p_vs = vif.vsync_n; p_prt = vif.printting; p_fs = vif.frame_start;
        hs_in = 0; vs_in = 0; prt_in = 0;
        hs_last = 0; vs_last = 0; prt_last = 0; fs_last = 0;
        hs_falls = 0; hs_lows = 0; hs_bad_per = 0; hs_bad_low = 0;
        vs_falls = 0; vs_lows = 0; vs_bad_per = 0; vs_bad_low = 0;
        prt_runs = 0; prt_bad = 0; fs_hi = 0; fs_pulses = 0; fs_bad = 0; col_bad = 0;
        for (int unsigned t = 1; t <= n; t++) begin
            @(negedge clk);
            if (p_hs && !vif.hsync_n) begin
                if (hs_falls > 0 && t - hs_last != 1600) hs_bad_per++;
                hs_falls++; hs_last = t; hs_in = 1;
            end
            if (!p_hs && vif.hsync_n && hs_in) begin
                if (t - hs_last != 192) hs_bad_low++;
                hs_lows++; hs_in = 0;
            end
            if (p_vs && !vif.vsync_n) begin
                if (vs_falls > 0 && t - vs_last != 19200) vs_bad_per++;
                vs_falls++; vs_last = t; vs_in = 1;
            end
            if (!p_vs && vif.vsync_n && vs_in) begin
                if (t - vs_last != 3200) vs_bad_low++;
                vs_lows++; vs_in = 0;
            end
            if (!p_prt && vif.printting) begin
                prt_last = t; prt_in = 1;
            end
            if (p_prt && !vif.printting && prt_in) begin
                if (t - prt_last != 1280) prt_bad++;
                prt_runs++; prt_in = 0;
            end
            if (vif.frame_start) fs_hi++;
            if (!p_fs && vif.frame_start) begin
                if (fs_pulses > 0 && t - fs_last != 19200) fs_bad++;
                fs_pulses++; fs_last = t;
            end
            if (!vif.printting && (vif.color_r_readdata != 0 || vif.color_g_readdata != 0 ||
                                   vif.color_b_readdata != 0)) col_bad++;
            if (vif.printting && (vif.color_r_readdata != vif.color_g_readdata ||
                                  vif.color_g_readdata != vif.color_b_readdata)) col_bad++;
            p_hs = vif.hsync_n; p_vs = vif.vsync_n; p_prt = vif.printting; p_fs = vif.frame_start;
        end
        chk("run.hsync_falls", hs_falls, 23);
        chk("run.hsync_period_bad", hs_bad_per, 0);
        chk("run.hsync_lows", hs_lows, 23);
        chk("run.hsync_low_bad", hs_bad_low, 0);
        chk("run.printting_runs", prt_runs, 10);
        chk("run.printting_len_bad", prt_bad, 0);
        chk("run.vsync_falls", vs_falls, 2);
        chk("run.vsync_period_bad", vs_bad_per, 0);
        chk("run.vsync_lows", vs_lows, 2);
        chk("run.vsync_low_bad", vs_bad_low, 0);
        chk("run.frame_start_clks", fs_hi, 2);
        chk("run.frame_start_period_bad", fs_bad, 0);
        chk("run.colour_bad", col_bad, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz, prt_cnt, hs_low, vs_low, hs_res;
        int unsigned g;

        //    c     px   py preq fs hs vs prt cr
        add(   1,   0,  0,  0,  0, 1, 1, 0, 0);
        add(   2,   0,  0,  1,  1, 1, 1, 0, 0);
        add(   3,   0,  0,  1,  0, 1, 1, 0, 0);
        add(   4,   1,  0,  1,  0, 1, 1, 0, 0);
        add(   5,   1,  0,  1,  0, 1, 1, 0, 0);
        add(   6,   2,  0,  1,  0, 1, 1, 1, 0);
        add(   7,   2,  0,  1,  0, 1, 1, 1, 0);
        add(  16,   7,  0,  1,  0, 1, 1, 1, 5);
        add(1281, 639,  0,  1,  0, 1, 1, 1, 5);
        add(1282, 640,  0,  0,  0, 1, 1, 1, 6);
        add(1285, 641,  0,  0,  0, 1, 1, 1, 7);
        add(1286, 642,  0,  0,  0, 1, 1, 0, 0);
        add(1317, 657,  0,  0,  0, 1, 1, 0, 0);
        add(1318, 658,  0,  0,  0, 0, 1, 0, 0);
        add(1509, 753,  0,  0,  0, 0, 1, 0, 0);
        add(1510, 754,  0,  0,  0, 1, 1, 0, 0);
        add(1601, 799,  0,  0,  0, 1, 1, 0, 0);
        add(1602,   0,  1,  1,  0, 1, 1, 0, 0);
        add(1606,   2,  1,  1,  0, 1, 1, 1, 0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("cold_reset");
        rst = 1'b0;
        run_table("cold");

        monitor(38000);

        // Enable low for one whole line with the source driving full white.
        white = 1'b1;
        wait_xy(10'd0, 10'd2, "en.wait_line2");
        vif.enable = 1'b0;
        nz = 0; prt_cnt = 0; hs_low = 0; vs_low = 0;
        for (int k = 0; k < 1600; k++) begin
            @(negedge clk);
            if (vif.color_r_readdata != 0 || vif.color_g_readdata != 0 ||
                vif.color_b_readdata != 0) nz++;
            if (vif.printting) prt_cnt++;
            if (!vif.hsync_n) hs_low++;
            if (!vif.vsync_n) vs_low++;
        end
        vif.enable = 1'b1;
        chk("en.colour_nonzero", nz, 0);
        chk("en.printting_clks", prt_cnt, 1280);
        chk("en.hsync_low_clks", hs_low, 192);
        chk("en.vsync_low_clks", vs_low, 0);
        g = 0;
        while (!vif.printting && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("en.resume_printting", int'(vif.printting), 1);
        chk("en.resume_r", int'(vif.color_r_readdata), 7);
        chk("en.resume_g", int'(vif.color_g_readdata), 7);
        chk("en.resume_b", int'(vif.color_b_readdata), 7);
        white = 1'b0;

        // One-clock reset mid-frame, then a full cold-start replay.
        wait_xy(10'd300, 10'd4, "mid.wait");
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b0;
        run_table("restart");

        // Reset while hsync_n is low must not leave a trailing sync pulse.
        wait_xy(10'd700, 10'd1, "hsr.wait");
        chk("hsr.pre_hsync_n", int'(vif.hsync_n), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("hsr.hsync_n", int'(vif.hsync_n), 1);
        rst = 1'b0;
        hs_res = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!vif.hsync_n) hs_res++;
        end
        chk("hsr.residual_low_clks", hs_res, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
